// File: rtl/krypton_pkg.sv
// Shared glyph constants and fetch-state encoding for the Krypton character generator.
package krypton_pkg;

  localparam int GLYPH_W      = 8;
  localparam int GLYPH_H      = 8;
  localparam int CODE_WIDTH   = 8;
  localparam int ROW_WIDTH    = $clog2(GLYPH_H);
  localparam int GLYPH_ADDR_W = CODE_WIDTH + ROW_WIDTH;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_ADDR = 2'd1,
    F_CAPT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/krypton_glyph_shifter.sv
// MSB-first pixel serializer for one glyph row, with ready/valid output handshake.
module krypton_glyph_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_pix_ready,
  output logic                  o_pix,
  output logic                  o_pix_valid,
  output logic                  o_pix_last,
  output logic                  o_empty,
  output logic                  o_last_hs
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic                  vld_q, vld_d;
  logic                  last, hs;

  assign last = vld_q && (idx_q == CW'(DATA_WIDTH - 1));
  assign hs   = vld_q && i_pix_ready;

  // A load on the last handshake refills in the same edge, so rows run back to back.
  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    vld_d = vld_q;
    if (i_flush) begin
      vld_d = 1'b0;
      idx_d = '0;
    end else if (i_load) begin
      sh_d  = i_load_data;
      idx_d = '0;
      vld_d = 1'b1;
    end else if (hs) begin
      sh_d  = sh_q << 1;
      idx_d = idx_q + 1'b1;
      if (last) begin
        vld_d = 1'b0;
        idx_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sh_q  <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end

  assign o_pix       = sh_q[DATA_WIDTH-1];
  assign o_pix_valid = vld_q;
  assign o_pix_last  = last;
  assign o_empty     = !vld_q;
  assign o_last_hs   = hs && last;

endmodule

// File: rtl/krypton_glyph_fetch.sv
// Glyph-row fetch: ROM address/capture FSM, one-row prefetch buffer, pixel serializer.
module krypton_glyph_fetch
  import krypton_pkg::*;
#(
  parameter int ADDR_WIDTH = krypton_pkg::GLYPH_ADDR_W,
  parameter int DATA_WIDTH = krypton_pkg::GLYPH_W,
  parameter int CODE_WIDTH = krypton_pkg::CODE_WIDTH,
  parameter int ROW_WIDTH  = krypton_pkg::ROW_WIDTH
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [CODE_WIDTH-1:0] i_char_code,
  input  logic [ROW_WIDTH-1:0]  i_row,
  input  logic                  i_invert,
  output logic [ADDR_WIDTH-1:0] o_rom_adr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic                  o_pix_valid,
  input  logic                  i_pix_ready,
  output logic                  o_pix,
  output logic                  o_pix_last,
  input  logic                  i_flush
);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] rom_adr_q;
  logic                  inv_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic                  buf_vld_q;
  logic                  accept, sh_load, sh_empty, sh_last_hs;

  assign o_req_ready = (state_q == F_IDLE) && !buf_vld_q && !i_flush;
  assign accept      = i_req_valid && o_req_ready;
  assign sh_load     = buf_vld_q && (sh_empty || sh_last_hs) && !i_flush;
  assign o_rom_adr   = rom_adr_q;

  // Accept only with an empty buffer, so F_CAPT never collides with a buffer drain.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q   <= F_IDLE;
      rom_adr_q <= '0;
      inv_q     <= 1'b0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
    end else if (i_flush) begin
      state_q   <= F_IDLE;
      buf_vld_q <= 1'b0;
    end else begin
      if (sh_load) buf_vld_q <= 1'b0;
      case (state_q)
        F_IDLE: if (accept) begin
          rom_adr_q <= ADDR_WIDTH'({i_char_code, i_row});
          inv_q     <= i_invert;
          state_q   <= F_ADDR;
        end
        F_ADDR: state_q <= F_CAPT;
        F_CAPT: begin
          buf_q     <= i_rom_data ^ {DATA_WIDTH{inv_q}};
          buf_vld_q <= 1'b1;
          state_q   <= F_IDLE;
        end
        default: state_q <= F_IDLE;
      endcase
    end
  end

  krypton_glyph_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .i_clk       (i_sys_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_load      (sh_load),
    .i_load_data (buf_q),
    .i_pix_ready (i_pix_ready),
    .o_pix       (o_pix),
    .o_pix_valid (o_pix_valid),
    .o_pix_last  (o_pix_last),
    .o_empty     (sh_empty),
    .o_last_hs   (sh_last_hs)
  );

endmodule

// File: tb/tb_krypton_glyph_fetch.sv
// Bench for krypton_glyph_fetch: directed vector table, corner sequences, random vs queue model.
module tb_krypton_glyph_fetch;

  localparam int AW = 11, DW = 8, CW = 8, RW = 3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, invert = 1'b0, pix_ready = 1'b0, flush = 1'b0;
  logic [CW-1:0] code = '0;
  logic [RW-1:0] row = '0;
  logic          req_ready, pix_valid, pix, pix_last;
  logic [AW-1:0] rom_adr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] rom [0:(1<<AW)-1];
  int            checks = 0, failures = 0;

  typedef struct packed {
    logic [7:0] code;
    logic [2:0] row;
    logic       inv;
    logic [7:0] romv;
    logic [7:0] pixels;
  } vec_t;

  typedef struct packed {
    logic b;
    logic l;
  } px_t;

  vec_t vt [6];
  px_t  q [$];

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_adr];

  krypton_glyph_fetch dut (
    .i_sys_clk   (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_char_code (code),
    .i_row       (row),
    .i_invert    (invert),
    .o_rom_adr   (rom_adr),
    .i_rom_data  (rom_data),
    .o_pix_valid (pix_valid),
    .i_pix_ready (pix_ready),
    .o_pix       (pix),
    .o_pix_last  (pix_last),
    .i_flush     (flush)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!pix_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " wait valid"}, pix_valid, 1);
  endtask

  task automatic quiet(input string nm);
    int v;
    v = 0;
    for (int i = 0; i < 14; i++) begin
      if (pix_valid) v++;
      tick();
    end
    chk({nm, " quiet"}, v, 0);
  endtask

  // Cycle-exact single-row fetch: address at N+1, pixels N+4..N+11.
  task automatic fetch_row(input vec_t v, input string nm);
    rom[{v.code, v.row}] = v.romv;
    chk({nm, " ready"}, req_ready, 1);
    req_valid = 1'b1; code = v.code; row = v.row; invert = v.inv; pix_ready = 1'b1;
    tick();
    req_valid = 1'b0; invert = 1'b0;
    chk({nm, " adr"}, rom_adr, {v.code, v.row});
    tick();
    tick();
    chk({nm, " early"}, pix_valid, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk({nm, " valid"}, pix_valid, 1);
      chk({nm, " pix"}, pix, v.pixels[7-k]);
      chk({nm, " last"}, pix_last, (k == 7));
      tick();
    end
    chk({nm, " done"}, pix_valid, 0);
  endtask

  task automatic back_to_back();
    logic [15:0] exp16;
    int acc, vc, run, maxrun, lasts, errs;
    rom[{8'h50, 3'd0}] = 8'h96;
    rom[{8'h51, 3'd1}] = 8'h0F;
    exp16 = 16'h960F;
    acc = 0; vc = 0; run = 0; maxrun = 0; lasts = 0; errs = 0;
    pix_ready = 1'b1; req_valid = 1'b1; code = 8'h50; row = 3'd0; invert = 1'b0;
    for (int c = 0; c < 40; c++) begin
      logic a;
      a = req_valid && req_ready;
      if (pix_valid) begin
        if (vc < 16 && pix !== exp16[15-vc]) errs++;
        vc++;
        run++;
        if (pix_last) lasts++;
      end else run = 0;
      if (run > maxrun) maxrun = run;
      tick();
      if (a) begin
        acc++;
        if (acc == 2) req_valid = 1'b0;
        else begin code = 8'h51; row = 3'd1; end
      end
    end
    chk("b2b accepts", acc, 2);
    chk("b2b valid count", vc, 16);
    chk("b2b longest run", maxrun, 16);
    chk("b2b last count", lasts, 2);
    chk("b2b data errs", errs, 0);
  endtask

  task automatic stall_seq();
    logic [7:0] e;
    e = 8'hB2;
    rom[{8'h60, 3'd2}] = e;
    pix_ready = 1'b1; req_valid = 1'b1; code = 8'h60; row = 3'd2;
    tick();
    req_valid = 1'b0;
    wait_valid("stall");
    for (int k = 0; k < 3; k++) begin
      chk("stall pre pix", pix, e[7-k]);
      tick();
    end
    pix_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall hold valid", pix_valid, 1);
      chk("stall hold pix", pix, e[4]);
      chk("stall hold last", pix_last, 0);
      tick();
    end
    pix_ready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      chk("stall post valid", pix_valid, 1);
      chk("stall post pix", pix, e[7-k]);
      chk("stall post last", pix_last, (k == 7));
      tick();
    end
    chk("stall done", pix_valid, 0);
  endtask

  // Start a row, queue a second one in the prefetch buffer, kill both at pixel 5.
  task automatic kill_seq(input bit use_rst);
    logic [7:0] e;
    string nm;
    nm = use_rst ? "reset" : "flush";
    e = 8'hE7;
    rom[{8'h70, 3'd4}] = e;
    rom[{8'h71, 3'd0}] = 8'h55;
    pix_ready = 1'b1; req_valid = 1'b1; code = 8'h70; row = 3'd4;
    tick();
    req_valid = 1'b0;
    wait_valid(nm);
    chk({nm, " req2 ready"}, req_ready, 1);
    req_valid = 1'b1; code = 8'h71; row = 3'd0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk({nm, " pix5 valid"}, pix_valid, 1);
    chk({nm, " pix5"}, pix, e[3]);
    if (use_rst) begin
      rst_n = 1'b0;
      tick();
      chk("reset mid valid", pix_valid, 0);
      chk("reset mid adr", rom_adr, 0);
      tick();
      rst_n = 1'b1;
      tick();
    end else begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
    end
    chk({nm, " after valid"}, pix_valid, 0);
    chk({nm, " after ready"}, req_ready, 1);
    quiet(nm);
  endtask

  task automatic random_run();
    px_t e;
    logic [7:0] w;
    q.delete();
    for (int a = 0; a < (1 << AW); a++) rom[a] = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      code      = 8'($urandom);
      row       = 3'($urandom);
      invert    = 1'($urandom);
      pix_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      if (flush) q.delete();
      else begin
        if (pix_valid && pix_ready) begin
          if (q.size() == 0) chk("rnd spurious pixel", 1, 0);
          else begin
            e = q.pop_front();
            chk("rnd pix", pix, e.b);
            chk("rnd last", pix_last, e.l);
          end
        end
        if (req_valid && req_ready) begin
          w = rom[{code, row}] ^ (invert ? 8'hFF : 8'h00);
          for (int i = 0; i < 8; i++) begin
            e.b = w[7-i];
            e.l = (i == 7);
            q.push_back(e);
          end
        end
      end
      tick();
    end
    req_valid = 1'b0; flush = 1'b0; pix_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pix_valid) begin
        if (q.size() == 0) chk("drain spurious pixel", 1, 0);
        else begin
          e = q.pop_front();
          chk("drain pix", pix, e.b);
          chk("drain last", pix_last, e.l);
        end
      end
      tick();
    end
    chk("rnd queue empty", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{code: 8'h41, row: 3'd3, inv: 1'b0, romv: 8'h3C, pixels: 8'h3C};
    vt[1] = '{code: 8'h41, row: 3'd3, inv: 1'b1, romv: 8'h3C, pixels: 8'hC3};
    vt[2] = '{code: 8'h00, row: 3'd0, inv: 1'b0, romv: 8'h81, pixels: 8'h81};
    vt[3] = '{code: 8'hFF, row: 3'd7, inv: 1'b1, romv: 8'hFF, pixels: 8'h00};
    vt[4] = '{code: 8'h7E, row: 3'd5, inv: 1'b1, romv: 8'hA5, pixels: 8'h5A};
    vt[5] = '{code: 8'h12, row: 3'd1, inv: 1'b0, romv: 8'h01, pixels: 8'h01};
    for (int a = 0; a < (1 << AW); a++) rom[a] = '0;

    tick();
    tick();
    chk("rst adr", rom_adr, 0);
    chk("rst valid", pix_valid, 0);
    chk("rst pix", pix, 0);
    chk("rst last", pix_last, 0);
    chk("rst ready", req_ready, 1);
    rst_n = 1'b1;
    tick();

    fetch_row(vt[0], "basic");
    chk("basic adr 20b", rom_adr, 11'h20B);
    for (int i = 1; i < 6; i++) fetch_row(vt[i], $sformatf("vec%0d", i));

    back_to_back();
    tick();
    stall_seq();
    tick();
    kill_seq(1'b0);
    kill_seq(1'b1);
    random_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
